// File: rtl/norm_share_arbiter.sv
// norm_share_arbiter
// Round-robin arbiter that time-shares one combinational normalization unit
// between NREQ MAC lanes. The granted lane's raw mantissa/exponent drive the
// norm_* outputs, and the normalizer's answer is post-processed for overflow
// and zero, then captured in a single output register tagged with the lane id.
// One result per cycle; the output register reloads in the cycle it drains.
//
// Optional feature: define NORM_ARB_OVF_CNT_EN to add the ovf_count output,
// a saturating 16-bit count of results loaded with out_ovf=1.

module norm_share_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  // requester side
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_sign,
  input  logic [NREQ*25-1:0]   req_res,
  input  logic [NREQ*8-1:0]    req_exp,
  // shared normalizer
  output logic [24:0]          norm_res,
  output logic [7:0]           norm_exp_base,
  input  logic [23:0]          norm_man,
  input  logic [7:0]           norm_exp,
  input  logic                 norm_ovf,
  // result side
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [23:0]          out_man,
  output logic [7:0]           out_exp,
  output logic                 out_ovf,
  output logic [ID_W-1:0]      out_id
`ifdef NORM_ARB_OVF_CNT_EN
  ,
  output logic [15:0]          ovf_count
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sign_q, out_sign_d;
  logic [23:0]     out_man_q, out_man_d;
  logic [7:0]      out_exp_q, out_exp_d;
  logic            out_ovf_q, out_ovf_d;
  logic [ID_W-1:0] out_id_q, out_id_d;

  // ---------------------------------------------------------------------------
  // Combinational datapath signals
  // ---------------------------------------------------------------------------
  logic            load;
  logic            grant_valid;
  logic [ID_W-1:0] grant_idx;
  logic            transfer;
  logic [24:0]     sel_res;
  logic [7:0]      sel_exp;
  logic            sel_sign;
  logic            res_ovf;
  logic [23:0]     res_man;
  logic [7:0]      res_exp;

  // Index base+off reduced modulo NREQ; off is always below NREQ so one
  // conditional subtraction suffices, and non-power-of-two NREQ works.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return ID_W'(sum);
  endfunction

  // The output register can take a new result when empty or draining now.
  assign load = ~out_valid_q | out_ready;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop; a
    // path that leaves one unassigned would infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!grant_valid && req_valid[wrap_idx(rr_ptr_q, off)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_q, off);
      end
    end
  end

  // Acceptance is blocked during reset so nothing is lost to the clear.
  assign transfer = grant_valid & load & ~rst;

  // One-hot ready to the granted requester only.
  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
  end

  // Mux the granted requester's operands; idle drives zeros so the shared
  // normalizer sees a constant input and does not toggle.
  always_comb begin
    sel_res  = '0;
    sel_exp  = '0;
    sel_sign = 1'b0;
    if (grant_valid) begin
      sel_res  = req_res[grant_idx*25 +: 25];
      sel_exp  = req_exp[grant_idx*8 +: 8];
      sel_sign = req_sign[grant_idx];
    end
  end

  assign norm_res      = sel_res;
  assign norm_exp_base = sel_exp;

  // Special-case the normalizer result: overflow (including the exponent
  // wrap the normalizer cannot flag itself) becomes infinity, a zero raw
  // mantissa becomes signed zero, everything else passes through.
  always_comb begin
    res_ovf = 1'b0;
    res_man = norm_man;
    res_exp = norm_exp;
    if (norm_ovf || (sel_exp == 8'hFF && sel_res[24])) begin
      res_ovf = 1'b1;
      res_man = '0;
      res_exp = 8'hFF;
    end else if (sel_res == '0) begin
      res_man = '0;
      res_exp = '0;
    end
  end

  // Next-state for the pointer and output register.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_man_d   = out_man_q;
    out_exp_d   = out_exp_q;
    out_ovf_d   = out_ovf_q;
    out_id_d    = out_id_q;
    if (transfer) begin
      rr_ptr_d    = wrap_idx(grant_idx, 1);
      out_valid_d = 1'b1;
      out_sign_d  = sel_sign;
      out_man_d   = res_man;
      out_exp_d   = res_exp;
      out_ovf_d   = res_ovf;
      out_id_d    = grant_idx;
    end else if (out_ready) begin
      // Drained with nothing to replace it: payload fields keep their value.
      out_valid_d = 1'b0;
    end
  end

  // Pointer and output register; asynchronous reset discards held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_man_q   <= '0;
      out_exp_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_id_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers sampling the
      // pre-edge values, regardless of statement order.
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_man_q   <= out_man_d;
      out_exp_q   <= out_exp_d;
      out_ovf_q   <= out_ovf_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_man   = out_man_q;
  assign out_exp   = out_exp_q;
  assign out_ovf   = out_ovf_q;
  assign out_id    = out_id_q;

`ifdef NORM_ARB_OVF_CNT_EN
  logic [15:0] ovf_count_q, ovf_count_d;

  // Saturating count of overflow results entering the output register.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (transfer && res_ovf && ovf_count_q != 16'hFFFF)
      ovf_count_d = ovf_count_q + 16'd1;
  end

  // Overflow counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_count_q <= '0;
    else     ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule
